// File: rtl/shift_pkg.sv
// Shared definitions for the 4-bit unshifter.
//   - Bit positions of the fields inside the control word B
//     (fill in bit 0, amount above it, direction on top).
//   - FSM state encoding.
package shift_pkg;

  localparam int WIDTH    = 4;
  localparam int AW       = $clog2(WIDTH);

  localparam int FILL_BIT = 0;
  localparam int AMT_LSB  = 1;
  localparam int AMT_MSB  = AW;
  localparam int DIR_BIT  = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_cmd_decode.sv
// Combinational decode of the control word B.
//   b_i        : control word {dir, amount, fill}
//   dir_o      : 0 = the upstream shift was left, 1 = right
//   amt_o      : shift amount n
//   fill_o     : fill bit that should occupy the vacated positions of X
//   vac_mask_o : ones where X holds vacated (filled) bits
//                (low n bits for a left shift, high n bits for a right shift)
module shift_cmd_decode
  import shift_pkg::*;
#(
  parameter  int WIDTH = shift_pkg::WIDTH,
  localparam int CAW   = $clog2(WIDTH)
) (
  input  logic [DIR_BIT:0] b_i,
  output logic             dir_o,
  output logic [CAW-1:0]   amt_o,
  output logic             fill_o,
  output logic [WIDTH-1:0] vac_mask_o
);

  logic [WIDTH-1:0] low_mask;
  logic [WIDTH-1:0] high_mask;

  always_comb begin
    dir_o  = b_i[DIR_BIT];
    amt_o  = b_i[AMT_MSB:AMT_LSB];
    fill_o = b_i[FILL_BIT];

    // n ones at the bottom / top of the word; both are zero for n = 0.
    low_mask  = ~({WIDTH{1'b1}} << amt_o);
    high_mask = ~({WIDTH{1'b1}} >> amt_o);

    vac_mask_o = dir_o ? high_mask : low_mask;
  end

endmodule

// File: rtl/unshifter_4b.sv
// Rebuilds the operand A of shifter_4b from its result X, shifted-out bits Y
// and control word B, moving one bit per clock, and flags X whose vacated
// bits do not match the fill bit.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : command handshake (X, Y, B sampled on acceptance)
//   X, Y, B           : shifted result, shifted-out bits, {dir, amount, fill}
//   out_valid/out_ready: result handshake
//   A, fill_err       : restored operand and vacated-bit mismatch flag
module unshifter_4b
  import shift_pkg::*;
#(
  parameter  int WIDTH = shift_pkg::WIDTH,
  localparam int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [AW+1:0]    B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] A,
  output logic             fill_err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] ysh_q, ysh_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             ferr_q, ferr_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             ferr_out_q, ferr_out_d;

  logic             cmd_dir;
  logic [AW-1:0]    cmd_amt;
  logic             cmd_fill;
  logic [WIDTH-1:0] cmd_mask;

  shift_cmd_decode #(
    .WIDTH (WIDTH)
  ) u_decode (
    .b_i        (B),
    .dir_o      (cmd_dir),
    .amt_o      (cmd_amt),
    .fill_o     (cmd_fill),
    .vac_mask_o (cmd_mask)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = (cmd_amt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (cnt_q == AW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    A         = a_q;
    fill_err  = ferr_out_q;
  end

  // Working registers: operand being rebuilt, remaining Y bits, step count.
  always_comb begin
    data_d     = data_q;
    ysh_d      = ysh_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    ferr_d     = ferr_q;
    a_d        = a_q;
    ferr_out_d = ferr_out_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d = X;
          ysh_d  = Y;
          cnt_d  = cmd_amt;
          dir_d  = cmd_dir;
          ferr_d = |((X ^ {WIDTH{cmd_fill}}) & cmd_mask);
        end
      end
      SHIFT: begin
        if (!dir_q) begin
          // Undo a left shift: Y[0] re-enters at the top first and is then
          // pushed down, so Y[n-1] ends up in A's MSB.
          data_d = {ysh_q[0], data_q[WIDTH-1:1]};
          ysh_d  = ysh_q >> 1;
        end else begin
          // Undo a right shift: Y[n-1] enters at the bottom first and is
          // pushed up, so Y[0] ends up in A's LSB.
          data_d = {data_q[WIDTH-2:0], ysh_q[cnt_q - AW'(1)]};
        end
        cnt_d = cnt_q - AW'(1);
      end
      default: ;
    endcase

    // A and fill_err only change when a result is published, so they stay
    // frozen during SHIFT and while DONE waits for out_ready.
    if ((state_q != DONE) && (state_d == DONE)) begin
      a_d        = data_d;
      ferr_out_d = ferr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q     <= '0;
      ysh_q      <= '0;
      cnt_q      <= '0;
      dir_q      <= 1'b0;
      ferr_q     <= 1'b0;
      a_q        <= '0;
      ferr_out_q <= 1'b0;
    end else begin
      data_q     <= data_d;
      ysh_q      <= ysh_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      ferr_q     <= ferr_d;
      a_q        <= a_d;
      ferr_out_q <= ferr_out_d;
    end
  end

endmodule

// File: tb/tb_unshifter_4b.sv
module tb_unshifter_4b;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] X;
  logic [3:0] Y;
  logic [3:0] B;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] A;
  logic       fill_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] a;
    logic       fe;
    int         lat;
  } exp_t;

  exp_t sb[$];

  unshifter_4b dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .Y         (Y),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .A         (A),
    .fill_err  (fill_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model written from the bit-level definition of the inverse shift.
  function automatic exp_t model(input logic [3:0] x, input logic [3:0] y, input logic [3:0] b);
    exp_t e;
    int   n;
    logic dir;
    logic fill;
    n    = int'(b[2:1]);
    dir  = b[3];
    fill = b[0];
    e.a  = x;
    e.fe = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!dir) begin
        if (i >= 4 - n) e.a[i] = y[i - (4 - n)];
        else            e.a[i] = x[i + n];
        if (i < n && x[i] !== fill) e.fe = 1'b1;
      end else begin
        if (i < n) e.a[i] = y[i];
        else       e.a[i] = x[i - n];
        if (i >= 4 - n && x[i] !== fill) e.fe = 1'b1;
      end
    end
    e.lat = n + 1;
    return e;
  endfunction

  task automatic run_cmd(input logic [3:0] x, input logic [3:0] y, input logic [3:0] b,
                         input int hold);
    exp_t e;
    int   cycles;
    sb.push_back(model(x, y, b));
    check("in_ready_idle", in_ready, 1);
    X = x; Y = y; B = b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    // Scramble the inputs: the command must already be captured.
    in_valid = 1'b0; X = ~x; Y = ~y; B = ~b;
    cycles = 1;
    while (!out_valid && cycles < 16) begin
      check("in_ready_busy", in_ready, 0);
      @(posedge clk); #1;
      cycles++;
    end
    e = sb.pop_front();
    if (!out_valid) begin
      check("timeout_out_valid", out_valid, 1);
      return;
    end
    check("latency", cycles, e.lat);
    check("A", A, e.a);
    check("fill_err", fill_err, e.fe);
    check("in_ready_done", in_ready, 0);
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_out_valid", out_valid, 1);
      check("hold_A", A, e.a);
      check("hold_fill_err", fill_err, e.fe);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_out_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
    check("post_A_kept", A, e.a);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    X = 4'h0; Y = 4'h0; B = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_A", A, 0);
    check("rst_fill_err", fill_err, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Left 1, fill 0
    run_cmd(4'b1110, 4'b0000, 4'b0010, 0);
    // Left 3, fill 0
    run_cmd(4'b1000, 4'b0011, 4'b0110, 0);
    // Right 1, fill 1
    run_cmd(4'b1011, 4'b0001, 4'b1011, 0);
    // Right 3, fill 0
    run_cmd(4'b0000, 4'b0111, 4'b1110, 0);
    // Amount 0: straight pass-through
    run_cmd(4'b0101, 4'b1010, 4'b0000, 0);
    // Bad fill on a left shift
    run_cmd(4'b1111, 4'b0000, 4'b0010, 0);
    // Bad fill on a right shift, upper Y bits set but unused
    run_cmd(4'b0110, 4'b1101, 4'b1100, 0);
    // Backpressure: result held for 5 cycles
    run_cmd(4'b1001, 4'b0101, 4'b1101, 5);

    for (int i = 0; i < 8; i++) begin
      run_cmd(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
    end

    // Make sure A is non-zero so the reset clearing it is visible.
    run_cmd(4'b1000, 4'b0011, 4'b0110, 0);
    check("pre_rst_A", A, 4'b0111);

    // Reset in the middle of SHIFT
    X = 4'b1000; Y = 4'b0011; B = 4'b0110; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("midshift_in_ready", in_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_A", A, 0);
    check("midrst_fill_err", fill_err, 0);
    repeat (4) begin
      @(posedge clk); #1;
      check("midrst_stays_idle", out_valid, 0);
    end

    // Reset while DONE waits on out_ready
    X = 4'b1111; Y = 4'b0000; B = 4'b0010; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("done_before_rst", out_valid, 1);
    check("done_fill_err", fill_err, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("donerst_out_valid", out_valid, 0);
    check("donerst_in_ready", in_ready, 1);
    check("donerst_A", A, 0);
    check("donerst_fill_err", fill_err, 0);

    // Recovery after reset
    run_cmd(4'b1011, 4'b0001, 4'b1011, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
